// File: rtl/axi_r_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_r_arbiter_pkg
// Description : Shared types and constants for the core AXI read-channel
//               arbiter: channel request/response structs, arbiter state
//               encoding and read-master indices.
// Contents    : axi_r_m2s_t  - master-to-slave AR/R signals
//               axi_r_s2m_t  - slave-to-master AR/R signals
//               arb_state_e  - arbiter FSM state encoding
// Revision    : 1.0 - initial release
// ============================================================================
package axi_r_arbiter_pkg;

  localparam int unsigned NumRdMasters = 2;
  localparam int unsigned RdMstIcache  = 0;
  localparam int unsigned RdMstDcache  = 1;

  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_DATA_W = 64;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic                  arvalid;
    logic [AXI_ADDR_W-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  rready;
  } axi_r_m2s_t;

  typedef struct packed {
    logic                  arready;
    logic                  rvalid;
    logic [AXI_DATA_W-1:0] rdata;
    logic                  rlast;
  } axi_r_s2m_t;

endpackage
`default_nettype wire

// File: rtl/axi_r_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : axi_r_arbiter_rr
// Description : Combinational round-robin pick. Scans the request vector
//               starting at index i_ptr (wrapping) and grants the first
//               active requester. Generic so a write-channel arbiter can
//               reuse it.
// Ports       : i_req [N]      - request vector
//               i_ptr [PTR_W]  - index where the search starts
//               o_gnt [N]      - one-hot grant, all-zero when no request
// Revision    : 1.0 - initial release
// ============================================================================
module axi_r_arbiter_rr #(
  parameter  int unsigned N     = 2,
  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt
);

  logic             w_found;
  logic [PTR_W-1:0] w_idx;

  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_idx = PTR_W'((32'(i_ptr) + i) % N);
      if (!w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi_r_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axi_r_arbiter
// Description : Shares the single core AXI read channel between
//               NUM_RD_MASTERS requesters (0 = icache, 1 = dcache). One
//               master owns the channel from AR acceptance through the
//               final R beat (rlast). Data path is purely combinational,
//               steered by the registered grant.
// Config      : OOO_RARB_DCACHE_PRIO_EN - when defined, fixed priority with
//               the highest index winning (no round-robin pointer);
//               otherwise round-robin, pointer advanced past the owner on
//               each completed transaction.
// Ports       : clk_i    - core clock
//               rst_ni   - asynchronous active-low reset
//               m_req_i  - per-master AR/R requests
//               m_rsp_o  - per-master AR/R responses
//               s_req_o  - to the shared AXI read port
//               s_rsp_i  - from the shared AXI read port
//               grant_o  - one-hot owner, zero when idle
//               busy_o   - high whenever a transaction is in progress
// Revision    : 1.0 - initial release
// ============================================================================
module axi_r_arbiter
  import axi_r_arbiter_pkg::*;
#(
  parameter int unsigned NUM_RD_MASTERS = NumRdMasters
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  axi_r_m2s_t [NUM_RD_MASTERS-1:0]      m_req_i,
  output axi_r_s2m_t [NUM_RD_MASTERS-1:0]      m_rsp_o,
  output axi_r_m2s_t                           s_req_o,
  input  axi_r_s2m_t                           s_rsp_i,
  output logic       [NUM_RD_MASTERS-1:0]      grant_o,
  output logic                                 busy_o
);

  localparam int unsigned IDX_W = (NUM_RD_MASTERS > 1) ? $clog2(NUM_RD_MASTERS) : 1;

  arb_state_e                r_state;
  arb_state_e                w_state_nxt;
  logic [NUM_RD_MASTERS-1:0] r_grant;
  logic [NUM_RD_MASTERS-1:0] w_req;
  logic [NUM_RD_MASTERS-1:0] w_pick;
  logic [IDX_W-1:0]          w_gidx;
  logic                      w_ar_hs;
  logic                      w_data_done;

  always_comb begin
    for (int unsigned k = 0; k < NUM_RD_MASTERS; k++) begin
      w_req[k] = m_req_i[k].arvalid;
    end
  end

  // Binary index of the current owner, used to steer the muxes.
  always_comb begin
    w_gidx = '0;
    for (int unsigned k = 0; k < NUM_RD_MASTERS; k++) begin
      if (r_grant[k]) begin
        w_gidx = IDX_W'(k);
      end
    end
  end

  assign w_ar_hs     = (r_state == ARB_ADDR) && m_req_i[w_gidx].arvalid && s_rsp_i.arready;
  assign w_data_done = (r_state == ARB_DATA) && s_rsp_i.rvalid && m_req_i[w_gidx].rready
                       && s_rsp_i.rlast;

`ifdef OOO_RARB_DCACHE_PRIO_EN
  // Fixed priority: highest index wins, so the dcache can starve the icache.
  always_comb begin
    w_pick = '0;
    for (int i = NUM_RD_MASTERS - 1; i >= 0; i--) begin
      if (w_req[i] && (w_pick == '0)) begin
        w_pick[i] = 1'b1;
      end
    end
  end
`else
  logic [IDX_W-1:0] r_rr;
  logic [IDX_W-1:0] w_rr_nxt;

  axi_r_arbiter_rr #(
    .N (NUM_RD_MASTERS)
  ) u_rr (
    .i_req (w_req),
    .i_ptr (r_rr),
    .o_gnt (w_pick)
  );

  // Next search starts just past the master that has just finished.
  always_comb begin
    if (32'(w_gidx) == NUM_RD_MASTERS - 1) begin
      w_rr_nxt = '0;
    end else begin
      w_rr_nxt = w_gidx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr <= '0;
    end else if (w_data_done) begin
      r_rr <= w_rr_nxt;
    end
  end
`endif

  // State and grant registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ARB_IDLE;
      r_grant <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ARB_IDLE) && (w_req != '0)) begin
        r_grant <= w_pick;
      end else if (w_data_done) begin
        r_grant <= '0;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE: if (w_req != '0) w_state_nxt = ARB_ADDR;
      ARB_ADDR: if (w_ar_hs)     w_state_nxt = ARB_DATA;
      ARB_DATA: if (w_data_done) w_state_nxt = ARB_IDLE;
      default:                   w_state_nxt = ARB_IDLE;
    endcase
  end

  // Output muxes: only the owner is connected, everyone else sees zeros.
  always_comb begin
    s_req_o = '0;
    m_rsp_o = '0;
    case (r_state)
      ARB_ADDR: begin
        s_req_o.arvalid          = m_req_i[w_gidx].arvalid;
        s_req_o.araddr           = m_req_i[w_gidx].araddr;
        s_req_o.arlen            = m_req_i[w_gidx].arlen;
        s_req_o.arsize           = m_req_i[w_gidx].arsize;
        s_req_o.arburst          = m_req_i[w_gidx].arburst;
        m_rsp_o[w_gidx].arready  = s_rsp_i.arready;
      end
      ARB_DATA: begin
        s_req_o.rready           = m_req_i[w_gidx].rready;
        m_rsp_o[w_gidx].rvalid   = s_rsp_i.rvalid;
        m_rsp_o[w_gidx].rdata    = s_rsp_i.rdata;
        m_rsp_o[w_gidx].rlast    = s_rsp_i.rlast;
      end
      default: ;
    endcase
  end

  assign grant_o = r_grant;
  assign busy_o  = (r_state != ARB_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_axi_r_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_r_arbiter
// Description : Self-checking bench for axi_r_arbiter. Stimulus tasks push
//               expected AR handshakes and R beats into queues; a monitor
//               on the falling edge pops and compares whenever the DUT
//               shows a handshake or a delivered beat.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_r_arbiter;
  import axi_r_arbiter_pkg::*;

  typedef struct {
    int          k;
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_exp_t;

  typedef struct {
    int          k;
    logic [63:0] data;
    logic        last;
  } r_exp_t;

  logic                   clk;
  logic                   rst_n;
  axi_r_m2s_t [1:0]       m_req;
  axi_r_s2m_t [1:0]       m_rsp;
  axi_r_m2s_t             s_req;
  axi_r_s2m_t             s_rsp;
  logic       [1:0]       grant;
  logic                   busy;

  ar_exp_t ar_q[$];
  r_exp_t  r_q[$];
  int      errors;
  int      checks;

  axi_r_arbiter #(.NUM_RD_MASTERS(2)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .m_req_i (m_req),
    .m_rsp_o (m_rsp),
    .s_req_o (s_req),
    .s_rsp_i (s_rsp),
    .grant_o (grant),
    .busy_o  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // A granted master must keep arvalid up until arready.
  property p_ar_hold;
    @(posedge clk) disable iff (!rst_n)
      (s_req.arvalid && !s_rsp.arready) |=> s_req.arvalid;
  endproperty
  a_ar_hold: assert property (p_ar_hold)
    else begin
      checks++;
      errors++;
      $display("FAIL ar_hold: arvalid dropped before arready (t=%0t)", $time);
    end

  // Monitor / scoreboard.
  always @(negedge clk) begin : mon
    ar_exp_t e;
    r_exp_t  r;
    int      owner;
    if (rst_n) begin
      if (s_req.arvalid && s_rsp.arready) begin
        if (ar_q.size() == 0) begin
          chk("ar_unexpected", 64'd1, 64'd0);
        end else begin
          e = ar_q.pop_front();
          chk("ar_grant", 64'(grant), 64'(2'b01 << e.k));
          chk("ar_addr",  64'(s_req.araddr), 64'(e.addr));
          chk("ar_len",   64'(s_req.arlen),  64'(e.len));
          for (int k = 0; k < 2; k++) begin
            chk("ar_ready_route", 64'(m_rsp[k].arready), 64'(k == e.k));
          end
        end
      end
      if (s_rsp.rvalid && (r_q.size() > 0)) begin
        owner = r_q[0].k;
        for (int k = 0; k < 2; k++) begin
          if (k != owner) begin
            chk("r_other_rvalid", 64'(m_rsp[k].rvalid), 64'd0);
            chk("r_other_rdata",  m_rsp[k].rdata, 64'd0);
            chk("r_other_rlast",  64'(m_rsp[k].rlast), 64'd0);
          end
        end
      end
      for (int k = 0; k < 2; k++) begin
        if (m_rsp[k].rvalid && m_req[k].rready) begin
          if (r_q.size() == 0) begin
            chk("r_unexpected", 64'd1, 64'd0);
          end else begin
            r = r_q.pop_front();
            chk("r_master", 64'(k), 64'(r.k));
            chk("r_data",   m_rsp[k].rdata, r.data);
            chk("r_last",   64'(m_rsp[k].rlast), 64'(r.last));
          end
        end
      end
    end
  end

  // Plays the slave side of one transaction expected to be owned by master k.
  task automatic serve(input int k, input logic [31:0] addr, input logic [7:0] len,
                       input int ar_stall, input logic [63:0] dbase, input bit tog);
    int cyc;
    int beat;
    bit acc;
    ar_q.push_back('{k, addr, len});
    for (int b = 0; b <= int'(len); b++) begin
      r_q.push_back('{k, dbase + 64'(b), (b == int'(len))});
    end
    cyc = 0;
    while (!s_req.arvalid && cyc < 50) begin
      step();
      cyc++;
    end
    if (!s_req.arvalid) begin
      chk("ar_timeout", 64'd0, 64'd1);
      return;
    end
    for (int s = 0; s < ar_stall; s++) begin
      step();
      chk("ar_stall_grant", 64'(grant), 64'(2'b01 << k));
    end
    s_rsp.arready = 1'b1;
    step();
    s_rsp.arready      = 1'b0;
    m_req[k].arvalid   = 1'b0;
    beat = 0;
    cyc  = 0;
    while (beat <= int'(len) && cyc < 100) begin
      s_rsp.rvalid   = 1'b1;
      s_rsp.rdata    = dbase + 64'(beat);
      s_rsp.rlast    = (beat == int'(len));
      m_req[k].rready = tog ? cyc[0] : 1'b1;
      acc = m_req[k].rready;
      step();
      cyc++;
      if (acc) beat++;
    end
    s_rsp.rvalid    = 1'b0;
    s_rsp.rlast     = 1'b0;
    s_rsp.rdata     = '0;
    m_req[k].rready = 1'b1;
    if (beat <= int'(len)) chk("r_timeout", 64'd0, 64'd1);
    chk("idle_after_rlast_busy",  64'(busy),  64'd0);
    chk("idle_after_rlast_grant", 64'(grant), 64'd0);
  endtask

  task automatic set_ar(input int k, input logic [31:0] addr, input logic [7:0] len);
    m_req[k].araddr  = addr;
    m_req[k].arlen   = len;
    m_req[k].arsize  = 3'd3;
    m_req[k].arburst = 2'd1;
    m_req[k].arvalid = 1'b1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    m_req  = '0;
    s_rsp  = '0;
    rst_n  = 1'b0;
    m_req[0].rready = 1'b1;
    m_req[1].rready = 1'b1;

    // Reset with both masters requesting.
    set_ar(0, 32'h3000_0000, 8'd1);
    set_ar(1, 32'h8000_1000, 8'd2);
    repeat (3) step();
    chk("reset_s_req", 64'(s_req), 64'd0);
    chk("reset_m_rsp", 64'(|m_rsp), 64'd0);
    chk("reset_grant", 64'(grant), 64'd0);
    chk("reset_busy",  64'(busy),  64'd0);
    rst_n = 1'b1;

`ifndef OOO_RARB_DCACHE_PRIO_EN
    // Round-robin: icache first, then dcache, then icache again.
    serve(0, 32'h3000_0000, 8'd1, 0, 64'h0000_00A0, 1'b0);
    set_ar(0, 32'h3000_0040, 8'd0);
    serve(1, 32'h8000_1000, 8'd2, 0, 64'h0000_00B0, 1'b0);
    serve(0, 32'h3000_0040, 8'd0, 0, 64'h0000_00C0, 1'b0);
`else
    // Fixed priority: dcache wins every time while icache keeps requesting.
    for (int t = 0; t < 3; t++) begin
      serve(1, 32'h8000_1000 + 32'(t * 64), 8'd1, 0, 64'h0000_0D00 + 64'(t * 16), 1'b0);
      if (t < 2) set_ar(1, 32'h8000_1000 + 32'((t + 1) * 64), 8'd1);
    end
    m_req[0].arvalid = 1'b0;
    step();
    chk("prio_icache_not_granted", 64'(grant), 64'd0);
`endif

    // Single icache read, one-cycle arbitration latency.
    step();
    set_ar(0, 32'h8000_0000, 8'd3);
    step();
    chk("latency_arvalid", 64'(s_req.arvalid), 64'd1);
    chk("latency_grant",   64'(grant), 64'd1);
    chk("latency_busy",    64'(busy),  64'd1);
    serve(0, 32'h8000_0000, 8'd3, 0, 64'h1111_0000_0000_0000, 1'b0);

    // Backpressure on arready and toggling rready.
    set_ar(0, 32'h8000_2000, 8'd3);
    serve(0, 32'h8000_2000, 8'd3, 5, 64'h2222_0000_0000_0010, 1'b1);

    // Reset in the middle of a burst, after two of four beats.
    set_ar(0, 32'h8000_3000, 8'd3);
    ar_q.push_back('{0, 32'h8000_3000, 8'd3});
    r_q.push_back('{0, 64'h0000_00E0, 1'b0});
    r_q.push_back('{0, 64'h0000_00E1, 1'b0});
    step();
    s_rsp.arready = 1'b1;
    step();
    s_rsp.arready    = 1'b0;
    m_req[0].arvalid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      s_rsp.rvalid = 1'b1;
      s_rsp.rdata  = 64'h0000_00E0 + 64'(b);
      s_rsp.rlast  = 1'b0;
      step();
    end
    s_rsp.rdata = 64'h0000_00E2;
    rst_n = 1'b0;
    #1;
    chk("midrst_s_req", 64'(s_req), 64'd0);
    chk("midrst_m_rsp", 64'(|m_rsp), 64'd0);
    chk("midrst_grant", 64'(grant), 64'd0);
    chk("midrst_busy",  64'(busy),  64'd0);
    step();
    chk("midrst_busy_edge", 64'(busy), 64'd0);
    s_rsp = '0;
    step();
    rst_n = 1'b1;
    chk("midrst_ar_q_empty", 64'(ar_q.size()), 64'd0);
    chk("midrst_r_q_empty",  64'(r_q.size()),  64'd0);
    set_ar(0, 32'h8000_4000, 8'd3);
    serve(0, 32'h8000_4000, 8'd3, 0, 64'h3333_0000_0000_0000, 1'b0);

    step();
    chk("end_ar_q_empty", 64'(ar_q.size()), 64'd0);
    chk("end_r_q_empty",  64'(r_q.size()),  64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
